// File: rtl/vram_fill_dma.sv
// vram_fill_dma: CPU-programmed block fill engine for video RAM.
// A CPU port register file (8 bytes at BASE_ADDR) sets start address,
// length and fill byte. A start command streams one byte per clock into
// video RAM until the length is exhausted or the CPU aborts.
// Optional macro FILL_PATTERN_EN adds a second fill byte (FILL_B) and
// alternates FILL_A / FILL_B on successive writes.
module vram_fill_dma #(
    parameter logic [15:0] BASE_ADDR = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Port_Add,
    input  logic [7:0]  Port_In,
    input  logic        Port_we,
    output logic [7:0]  Port_Out,
    output logic [14:0] Video_Add,
    output logic [7:0]  Video_Data,
    output logic        Video_we,
    output logic        busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;

    logic [7:0]  addr_lo_reg;
    logic [6:0]  addr_hi_reg;
    logic [7:0]  len_lo_reg;
    logic [7:0]  len_hi_reg;
    logic [7:0]  fill_a_reg;
    logic        done_reg;
    logic [14:0] cur_addr_reg;
    logic [15:0] remain_reg;

    logic [7:0]  reg_sel;
    logic [7:0]  cfg_we;
    logic        ctrl_wr;
    logic        start_req;
    logic        abort_req;
    logic        last_beat;
    logic [15:0] len_val;
    logic [15:0] eff_len;

    // One decode line per register offset; at most one is ever active.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign reg_sel[gi] = (Port_Add == 16'(BASE_ADDR + gi));
        end
    endgenerate

    // Configuration registers are frozen while a fill is running.
    assign cfg_we    = reg_sel & {8{Port_we}} & {8{state_reg == IDLE}};
    assign ctrl_wr   = Port_we && reg_sel[5];
    assign start_req = ctrl_wr && Port_In[0];
    assign abort_req = ctrl_wr && Port_In[1];
    assign len_val   = {len_hi_reg, len_lo_reg};
    assign eff_len   = (len_val > 16'h8000) ? 16'h8000 : len_val;
    assign last_beat = (remain_reg == 16'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state: start needs a non-zero length; abort or last byte ends a run.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_req && (len_val != 16'd0)) state_next = RUN;
            RUN:  if (abort_req || last_beat)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // CPU-writable configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_lo_reg <= '0;
            addr_hi_reg <= '0;
            len_lo_reg  <= '0;
            len_hi_reg  <= '0;
            fill_a_reg  <= '0;
        end else begin
            if (cfg_we[0]) addr_lo_reg <= Port_In;
            if (cfg_we[1]) addr_hi_reg <= Port_In[6:0];
            if (cfg_we[2]) len_lo_reg  <= Port_In;
            if (cfg_we[3]) len_hi_reg  <= Port_In;
            if (cfg_we[4]) fill_a_reg  <= Port_In;
        end
    end

    // Fill datapath: address pointer, remaining count and completion flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_reg <= '0;
            remain_reg   <= '0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        cur_addr_reg <= {addr_hi_reg, addr_lo_reg};
                        remain_reg   <= eff_len;
                        // A zero-length start completes immediately.
                        done_reg     <= (len_val == 16'd0);
                    end
                end
                RUN: begin
                    cur_addr_reg <= cur_addr_reg + 15'd1;
                    remain_reg   <= remain_reg - 16'd1;
                    if (last_beat && !abort_req) done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FILL_PATTERN_EN
    logic [7:0] fill_b_reg;
    logic       phase_reg;

    // Second fill byte and the alternation phase (first byte uses FILL_A).
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_b_reg <= '0;
            phase_reg  <= 1'b0;
        end else begin
            if (cfg_we[7]) fill_b_reg <= Port_In;
            if (state_reg == IDLE) phase_reg <= 1'b0;
            else                   phase_reg <= ~phase_reg;
        end
    end

    assign Video_Data = phase_reg ? fill_b_reg : fill_a_reg;
`else
    assign Video_Data = fill_a_reg;
`endif

    assign busy      = (state_reg == RUN);
    assign Video_we  = (state_reg == RUN);
    assign Video_Add = cur_addr_reg;

    // Readback mux; zero outside the decoded window so buses can be OR-ed.
    always_comb begin
        Port_Out = 8'h00;
        if (reg_sel[0]) Port_Out = addr_lo_reg;
        if (reg_sel[1]) Port_Out = {1'b0, addr_hi_reg};
        if (reg_sel[2]) Port_Out = len_lo_reg;
        if (reg_sel[3]) Port_Out = len_hi_reg;
        if (reg_sel[4]) Port_Out = fill_a_reg;
        if (reg_sel[6]) Port_Out = {6'b0, done_reg, busy};
`ifdef FILL_PATTERN_EN
        if (reg_sel[7]) Port_Out = fill_b_reg;
`endif
    end

endmodule

// File: tb/tb_vram_fill_dma.sv
// Testbench for vram_fill_dma: directed and randomized fills checked
// against an arithmetic model of the expected write stream.
module tb_vram_fill_dma;

    localparam logic [15:0] BASE = 16'hF000;

    logic        clk;
    logic        rst;
    logic [15:0] Port_Add;
    logic [7:0]  Port_In;
    logic        Port_we;
    logic [7:0]  Port_Out;
    logic [14:0] Video_Add;
    logic [7:0]  Video_Data;
    logic        Video_we;
    logic        busy;

    vram_fill_dma #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .Port_Add(Port_Add), .Port_In(Port_In), .Port_we(Port_we),
        .Port_Out(Port_Out),
        .Video_Add(Video_Add), .Video_Data(Video_Data), .Video_we(Video_we),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor: every observed video write and every busy cycle.
    logic [14:0] mon_addr[$];
    logic [7:0]  mon_data[$];
    int          busy_cycles = 0;

    always @(negedge clk) begin
        if (Video_we) begin
            mon_addr.push_back(Video_Add);
            mon_data.push_back(Video_Data);
        end
        if (busy) busy_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        Port_Add = BASE + {13'd0, off};
        Port_In  = d;
        Port_we  = 1'b1;
        @(posedge clk);
        #1;
        Port_we  = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [7:0] d);
        Port_Add = BASE + {13'd0, off};
        #1;
        d = Port_Out;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic program_regs(input logic [14:0] a, input logic [15:0] len,
                                input logic [7:0] fa, input logic [7:0] fb);
        wr(3'd0, a[7:0]);
        wr(3'd1, {1'b0, a[14:8]});
        wr(3'd2, len[7:0]);
        wr(3'd3, len[15:8]);
        wr(3'd4, fa);
        wr(3'd7, fb);
    endtask

    // Reference: byte i of a fill starting at a.
    function automatic logic [14:0] exp_addr(input logic [14:0] a, input int i);
        return 15'((int'(a) + i) % 32768);
    endfunction

    function automatic logic [7:0] exp_data(input int i, input logic [7:0] fa, input logic [7:0] fb);
`ifdef FILL_PATTERN_EN
        return (i % 2 == 1) ? fb : fa;
`else
        if (i < 0) return fb;
        return fa;
`endif
    endfunction

    // Programs a fill, starts it, waits for completion and compares the
    // captured stream with the model; full=0 checks only both ends.
    task automatic run_fill(input string tag, input logic [14:0] a, input logic [15:0] len,
                            input logic [7:0] fa, input logic [7:0] fb, input bit full);
        int base, bbase, eff, n, m;
        logic [7:0] st;
        program_regs(a, len, fa, fb);
        base  = mon_addr.size();
        bbase = busy_cycles;
        wr(3'd5, 8'h01);
        wait_idle(40000);
        eff = (int'(len) > 32768) ? 32768 : int'(len);
        n = mon_addr.size() - base;
        chk({tag, "_count"}, n, eff);
        chk({tag, "_busy"}, busy_cycles - bbase, eff);
        m = (n < eff) ? n : eff;
        if (full) begin
            for (int i = 0; i < m; i++) begin
                chk({tag, "_addr"}, mon_addr[base + i], exp_addr(a, i));
                chk({tag, "_data"}, mon_data[base + i], exp_data(i, fa, fb));
            end
        end else if (m > 0) begin
            chk({tag, "_first_addr"}, mon_addr[base], exp_addr(a, 0));
            chk({tag, "_last_addr"}, mon_addr[base + m - 1], exp_addr(a, m - 1));
            chk({tag, "_last_data"}, mon_data[base + m - 1], exp_data(m - 1, fa, fb));
        end
        rd(3'd6, st);
        chk({tag, "_status"}, st, 8'h02);
    endtask

    initial begin
        logic [7:0]  v;
        logic [7:0]  r [8];
        logic [14:0] a;
        logic [15:0] len;
        int          base, n;

        rst = 1'b1; Port_we = 1'b0; Port_Add = 16'h0000; Port_In = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_video_we", {31'd0, Video_we}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_video_add", Video_add_w(), 0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("rst_reg%0d", i), v, 0);
        end

        // Basic fill, wrap-around fill, clamped length, zero length.
        run_fill("basic", 15'h0100, 16'd4, 8'hAA, 8'h55, 1'b1);
        run_fill("wrap", 15'h7FFE, 16'd3, 8'h3C, 8'hC3, 1'b1);
        run_fill("clamp", 15'($urandom_range(0, 32767)), 16'h9000, 8'h5A, 8'hA5, 1'b0);
        run_fill("zero", 15'h0123, 16'd0, 8'h11, 8'h22, 1'b1);
        run_fill("pat", 15'h0040, 16'd3, 8'h12, 8'h34, 1'b1);

        // Randomized fills, some forced near the top of the address space.
        for (int t = 0; t < 8; t++) begin
            a   = (t % 2 == 0) ? 15'($urandom_range(32740, 32767)) : 15'($urandom_range(0, 32767));
            len = 16'($urandom_range(1, 48));
            run_fill($sformatf("rnd%0d", t), a, len, 8'($urandom), 8'($urandom), 1'b1);
        end

        // Readback of random values, ADDR_HI bit7 masked, CTRL reads 0, window edges.
        for (int i = 0; i < 8; i++) r[i] = 8'($urandom_range(1, 255));
        r[1][7] = 1'b1;
        wr(3'd0, r[0]); wr(3'd1, r[1]); wr(3'd2, r[2]); wr(3'd3, r[3]);
        wr(3'd4, r[4]); wr(3'd7, r[7]);
        rd(3'd0, v); chk("rb_addr_lo", v, r[0]);
        rd(3'd1, v); chk("rb_addr_hi", v, {1'b0, r[1][6:0]});
        rd(3'd2, v); chk("rb_len_lo", v, r[2]);
        rd(3'd3, v); chk("rb_len_hi", v, r[3]);
        rd(3'd4, v); chk("rb_fill_a", v, r[4]);
        rd(3'd5, v); chk("rb_ctrl", v, 0);
        rd(3'd7, v);
`ifdef FILL_PATTERN_EN
        chk("rb_fill_b", v, r[7]);
`else
        chk("rb_fill_b", v, 0);
`endif
        Port_Add = BASE + 16'd8; #1; chk("rb_above", Port_Out, 0);
        Port_Add = BASE - 16'd1; #1; chk("rb_below", Port_Out, 0);

        // Abort at the 10th write cycle; ADDR_LO write mid-fill is ignored.
        program_regs(15'h0200, 16'd100, 8'h77, 8'h88);
        base = mon_addr.size();
        wr(3'd5, 8'h01);
        repeat (3) begin @(posedge clk); #1; end
        wr(3'd0, 8'hEE);
        repeat (5) begin @(posedge clk); #1; end
        wr(3'd5, 8'h02);
        chk("abort_we_low", {31'd0, Video_we}, 0);
        repeat (4) begin @(posedge clk); #1; end
        n = mon_addr.size() - base;
        chk("abort_writes", {31'd0, (n == 10 || n == 11)}, 1);
        chk("abort_addr9", mon_addr[base + 9], 15'h0209);
        rd(3'd6, v); chk("abort_status", v, 0);
        rd(3'd0, v); chk("abort_addr_lo", v, 8'h00);

        // Start (and a LEN write) while busy are ignored.
        program_regs(15'h1000, 16'd20, 8'h9C, 8'hC9);
        base = mon_addr.size();
        wr(3'd5, 8'h01);
        repeat (4) begin @(posedge clk); #1; end
        wr(3'd5, 8'h01);
        wr(3'd2, 8'h05);
        wait_idle(100);
        n = mon_addr.size() - base;
        chk("rebusy_count", n, 20);
        chk("rebusy_last", mon_addr[base + n - 1], exp_addr(15'h1000, n - 1));
        rd(3'd2, v); chk("rebusy_len_lo", v, 8'd20);
        rd(3'd6, v); chk("rebusy_status", v, 8'h02);

        // Reset in the middle of a fill.
        program_regs(15'h2000, 16'd50, 8'h42, 8'h24);
        wr(3'd5, 8'h01);
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_video_we", {31'd0, Video_we}, 0);
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_video_add", Video_add_w(), 0);
        chk("mrst_video_data", Video_Data, 0);
        base = mon_addr.size();
        repeat (5) begin @(posedge clk); #1; end
        chk("mrst_no_writes", mon_addr.size() - base, 0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("mrst_reg%0d", i), v, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [31:0] Video_add_w();
        return {17'd0, Video_Add};
    endfunction

endmodule

// File: doc/vram_fill_dma.md
VRAM_FILL_DMA -- requirements
Module: vram_fill_dma

Interface
REQ-001 Parameter BASE_ADDR, default 16'hF000: port address of register 0; the block decodes BASE_ADDR..BASE_ADDR+7.
REQ-002 clk  in  1  single clock; the system drives it from the CPU clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Port_Add  in  16  CPU port address.
REQ-005 Port_In  in  8  CPU write data.
REQ-006 Port_we  in  1  CPU port write strobe, sampled on rising clk.
REQ-007 Port_Out  out  8  register read data; 8'h00 when Port_Add is outside the decoded range, so it can be OR-combined.
REQ-008 Video_Add  out  15  video RAM write address.
REQ-009 Video_Data  out  8  video RAM write data.
REQ-010 Video_we  out  1  video RAM write enable, one byte per clk.
REQ-011 busy  out  1  high while a fill is running.

Function
REQ-012 Register map at BASE_ADDR offset, write-only unless stated:
- +0 ADDR_LO.
- +1 ADDR_HI[6:0].
- +2 LEN_LO.
- +3 LEN_HI.
- +4 FILL_A.
- +5 CTRL: bit0 start, bit1 abort.
- +6 STATUS, read-only: bit0 busy, bit1 done.
- +7 FILL_B.
REQ-013 Readback of offsets 0-4 and 7 SHALL return the stored value (ADDR_HI bit7 reads 0); offset 5 reads 8'h00.
REQ-014 Port_Out SHALL be combinational from Port_Add and the current register/status state.
REQ-015 FSM states: IDLE and RUN. Transitions:
- IDLE->RUN on a CTRL write with bit0=1 and LEN!=0.
- RUN->IDLE when the remaining count reaches 0, or on a CTRL write with bit1=1.
REQ-016 Start with LEN==0: no Video_we pulses, busy stays 0, done set in the following cycle.
REQ-017 Effective length = min(LEN, 16'h8000); lengths above 32768 are clamped.
REQ-018 Start write sampled at edge N:
- Video_we=1 with Video_Add=ADDR during cycle N+1.
- Consecutive addresses each following cycle, exactly effective-length pulses with no gaps.
- busy=1 from N+1 through the last write cycle; busy=0 in the cycle after it.
REQ-019 Video_Add SHALL increment modulo 2^15 (7FFF wraps to 0000).
REQ-020 done SHALL set in the cycle busy falls after normal completion, clear on any start, and stay 0 after an abort.
REQ-021 Writes to offsets 0-4 and 7 while busy SHALL be ignored. A start while busy SHALL be ignored. A CTRL write with both bits set while busy is an abort.
REQ-022 Abort SHALL deassert Video_we from the next cycle onward; the byte written in the abort cycle completes.
REQ-023 Video_we SHALL be 0 whenever state is IDLE; Video_Add and Video_Data are don't-care when Video_we=0.

Reset
REQ-024 On rst high at a clk edge:
- State -> IDLE.
- All registers -> 0.
- busy=0, done=0, Video_we=0, Video_Add=0, Video_Data=0.
REQ-025 rst during RUN SHALL stop writes from the next cycle; no further Video_we pulses occur.

Configuration
REQ-026 Macro FILL_PATTERN_EN, when defined:
- Video_Data alternates FILL_A, FILL_B, FILL_A, ... starting with FILL_A at the first written byte.
- Offset +7 is implemented and reads back.
REQ-027 Without FILL_PATTERN_EN:
- Every byte is FILL_A.
- Writes to +7 are ignored and +7 reads 8'h00.

Verification
REQ-028 ADDR=0x0100, LEN=4, FILL_A=0xAA, start -> four Video_we cycles at 0100..0103, data 0xAA; busy high 4 cycles; STATUS then reads 0x02.
REQ-029 ADDR=0x7FFE, LEN=3, start -> writes at 7FFE, 7FFF, 0000.
REQ-030 LEN=0x9000, start -> exactly 32768 writes; busy high 32768 cycles.
REQ-031 LEN=0, start -> zero writes, busy never high, STATUS=0x02 next cycle.
REQ-032 LEN=100, start, CTRL=0x02 at the 10th write cycle -> 10 or 11 writes total; STATUS=0x00; ADDR_LO write during the fill reads back unchanged.
REQ-033 FILL_PATTERN_EN defined, FILL_A=0x12, FILL_B=0x34, LEN=3 -> data 12,34,12. Second run with rst asserted mid-fill -> Video_we low the next cycle and all registers read 0.
